acp_stream_writer: RTL and testbench

//  Upstream feeder of the accelerator's 64-bit ACP master port. Takes a valid/ready stream of
//  64-bit words plus a start command (base address, word count) and turns it into AXI

---
 rtl/acp_stream_writer_pkg.sv | 17 +
 rtl/acp_stream_writer_if.sv | 40 ++++
 rtl/acp_stream_writer_burst_len_calc.sv | 22 ++
 rtl/acp_stream_writer.sv | 133 +++++++++++++
 tb/tb_acp_stream_writer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acp_stream_writer_pkg.sv
// Shared ACP write-side constants and FSM state encodings for the stream writer.
package acp_stream_writer_pkg;

  localparam logic [3:0] AWCACHE_ACP = 4'b1111;
  localparam logic [4:0] AWUSER_ACP  = 5'b00001;
  localparam logic [2:0] AWPROT_ACP  = 3'b000;
  localparam logic [2:0] SIZE_64     = 3'd3;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [7:0] WSTRB_ALL   = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/acp_stream_writer_if.sv
// AXI3 write-only (AW/W/B) bundle between the stream writer and the PS ACP slave.
interface acp_stream_writer_if;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [4:0]  awuser;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awuser, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awuser, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/acp_stream_writer_burst_len_calc.sv
// Burst sizing: the largest burst that fits both the remaining word count and the
// space left before the next MAX_BEATS*8-byte boundary.
module acp_stream_writer_burst_len_calc #(
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = 20
) (
  input  logic [$clog2(MAX_BEATS)-1:0]   beat_off,
  input  logic [LEN_W-1:0]               remaining,
  output logic [$clog2(MAX_BEATS+1)-1:0] beats
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  logic [BEAT_W-1:0] room;
  logic [BEAT_W-1:0] cap;

  assign room  = BEAT_W'(MAX_BEATS) - BEAT_W'(beat_off);
  assign cap   = (remaining > LEN_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS)
                                                 : remaining[BEAT_W-1:0];
  assign beats = (cap < room) ? cap : room;

endmodule

// File: rtl/acp_stream_writer.sv
// Stream-to-ACP writer: chops a (base, word count) job into aligned AXI3 INCR bursts
// and tracks write responses until the job completes.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for start
//  ST_ADDR  | presenting AW for the next burst (stalls at MAX_OUTST)
//  ST_DATA  | streaming W beats straight from the input stream
//  ST_DRAIN | all data sent, waiting for the remaining BRESPs
module acp_stream_writer
  import acp_stream_writer_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = 20,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         cfg_addr,
  input  logic [LEN_W-1:0]    cfg_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [63:0]         s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  acp_stream_writer_if.master m_axi
);

  localparam int OFF_W  = $clog2(MAX_BEATS);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);

  logic [1:0]        state_q;
  logic [31:0]       addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [OUT_W-1:0]  outst_q;
  logic              err_q;

  logic [BEAT_W-1:0] beats;
  logic              aw_hs;
  logic              w_hs;
  logic              w_last_hs;
  logic              last_burst;

  acp_stream_writer_burst_len_calc #(
    .MAX_BEATS (MAX_BEATS),
    .LEN_W     (LEN_W)
  ) u_len_calc (
    .beat_off  (addr_q[OFF_W+2:3]),
    .remaining (rem_q),
    .beats     (beats)
  );

  assign aw_hs      = m_axi.awvalid && m_axi.awready;
  assign w_hs       = m_axi.wvalid && m_axi.wready;
  assign w_last_hs  = w_hs && m_axi.wlast;
  assign last_burst = (rem_q == LEN_W'(beats));

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(beats) - 8'd1;
  assign m_axi.awsize  = SIZE_64;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awcache = AWCACHE_ACP;
  assign m_axi.awuser  = AWUSER_ACP;
  assign m_axi.awprot  = AWPROT_ACP;
  assign m_axi.awvalid = (state_q == ST_ADDR) && (outst_q != OUT_W'(MAX_OUTST));

  // W is a pure passthrough of the input stream while a burst is open.
  assign m_axi.wdata  = s_tdata;
  assign m_axi.wstrb  = WSTRB_ALL;
  assign m_axi.wlast  = (state_q == ST_DATA) && (beat_cnt_q == '0);
  assign m_axi.wvalid = (state_q == ST_DATA) && s_tvalid;
  assign s_tready     = (state_q == ST_DATA) && m_axi.wready;

  assign m_axi.bready = 1'b1;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DRAIN) && (outst_q == '0);
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      outst_q <= outst_q + OUT_W'(w_last_hs) - OUT_W'(m_axi.bvalid);
      if (m_axi.bvalid && (m_axi.bresp != RESP_OKAY)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= cfg_addr;
            rem_q   <= cfg_words;
            err_q   <= 1'b0;
            state_q <= (cfg_words == '0) ? ST_DRAIN : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_hs) begin
            beat_cnt_q <= beats - BEAT_W'(1);
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (m_axi.wlast) begin
              addr_q  <= addr_q + (32'(beats) << 3);
              rem_q   <= rem_q - LEN_W'(beats);
              state_q <= last_burst ? ST_DRAIN : ST_ADDR;
            end else begin
              beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (outst_q == '0) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acp_stream_writer.sv
// Scoreboard bench for acp_stream_writer: a burst-splitting reference model fills expected
// AW/W queues, a randomised ACP slave and stream source drive the DUT, a monitor compares.
module tb_acp_stream_writer;

  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = 20;
  localparam int MAX_OUTST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      cfg_addr = '0;
  logic [LEN_W-1:0] cfg_words = '0;
  logic             busy, done, err;
  logic [63:0]      s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;

  acp_stream_writer_if axi ();

  always #5 clk = ~clk;

  acp_stream_writer #(
    .MAX_BEATS (MAX_BEATS),
    .LEN_W     (LEN_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_addr  (cfg_addr),
    .cfg_words (cfg_words),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_axi     (axi)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [63:0] data; logic last; } w_t;
  typedef struct { int due; logic [1:0] resp; } b_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [63:0] src_q[$];
  b_t          b_due[$];

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   done_cnt = 0, w_hs_cnt = 0, burst_idx = 0;
  int   tb_outst = 0, max_outst = 0;
  int   b_delay = 2, rdy_pct = 100, err_burst = -1;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the job in address order, cutting at each 128-byte line.
  task automatic plan_job(input logic [31:0] a, input int words);
    int          rem;
    int          room;
    int          b;
    logic [31:0] p;
    logic [63:0] d;
    rem = words;
    p   = a;
    while (rem > 0) begin
      room = MAX_BEATS - ((p / 8) % MAX_BEATS);
      b    = (rem < room) ? rem : room;
      exp_aw.push_back('{p, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        d = {$urandom, $urandom};
        src_q.push_back(d);
        exp_w.push_back('{d, (i == b - 1)});
      end
      p   = p + 32'(8 * b);
      rem = rem - b;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stream source: holds each word until accepted, random idle gaps.
  initial begin
    bit take;
    forever begin
      @(negedge clk);
      take = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (!s_tvalid || take) begin
        if (src_q.size() > 0 && $urandom_range(99) < rdy_pct) begin
          s_tvalid = 1'b1;
          s_tdata  = src_q[0];
        end else begin
          s_tvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      axi.awready = ($urandom_range(99) < rdy_pct);
      axi.wready  = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      if (b_due.size() > 0 && b_due[0].due <= cyc) begin
        axi.bvalid = 1'b1;
        axi.bresp  = b_due[0].resp;
        void'(b_due.pop_front());
      end
    end
  end

  initial begin
    aw_t ea;
    w_t  ew;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          done_cnt++;
          chk("done_aw_left", 64'(exp_aw.size()), 0);
          chk("done_w_left", 64'(exp_w.size()), 0);
          chk("done_outst", 64'(tb_outst), 0);
          chk("done_err", 64'(err), 64'(exp_err));
        end
        if (axi.awvalid && axi.awready) begin
          chk("aw_expected", 64'(exp_aw.size() > 0), 1);
          if (exp_aw.size() > 0) begin
            ea = exp_aw.pop_front();
            chk("awaddr", 64'(axi.awaddr), 64'(ea.addr));
            chk("awlen", 64'(axi.awlen), 64'(ea.len));
            chk("aw_attrs", 64'({axi.awsize, axi.awburst, axi.awcache, axi.awuser, axi.awprot}),
                64'({3'd3, 2'b01, 4'b1111, 5'b00001, 3'b000}));
          end
        end
        if (axi.wvalid && axi.wready) begin
          w_hs_cnt++;
          chk("w_expected", 64'(exp_w.size() > 0), 1);
          if (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            chk("wdata", axi.wdata, ew.data);
            chk("wlast", 64'(axi.wlast), 64'(ew.last));
            chk("wstrb", 64'(axi.wstrb), 64'hFF);
          end
          if (axi.wlast) begin
            b_due.push_back('{cyc + b_delay, (burst_idx == err_burst) ? 2'b10 : 2'b00});
            burst_idx++;
            tb_outst++;
          end
        end
        if (axi.bvalid) tb_outst--;
        if (tb_outst > max_outst) max_outst = tb_outst;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] a, input int words);
    @(posedge clk);
    #1;
    cfg_addr  = a;
    cfg_words = LEN_W'(words);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt >= target), 1);
  endtask

  task automatic run_job(input logic [31:0] a, input int words, input int delay,
                         input int pct, input int errb, input bit glitch, input string name);
    int target;
    b_delay   = delay;
    rdy_pct   = pct;
    err_burst = errb;
    burst_idx = 0;
    w_hs_cnt  = 0;
    exp_err   = (errb >= 0);
    plan_job(a, words);
    target = done_cnt + 1;
    pulse_start(a, words);
    chk({name, "_err_clear"}, 64'(err), 0);
    chk({name, "_busy"}, 64'(busy), 1);
    if (glitch) begin
      repeat (20) @(posedge clk);
      #1;
      chk({name, "_busy_at_glitch"}, 64'(busy), 1);
      cfg_addr  = 32'hDEAD_0000;
      cfg_words = LEN_W'(7);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(target, name);
    @(negedge clk);
    chk({name, "_idle_after"}, 64'(busy), 0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_busy"}, 64'(busy), 0);
    chk({name, "_done"}, 64'(done), 0);
    chk({name, "_err"}, 64'(err), 0);
    chk({name, "_awvalid"}, 64'(axi.awvalid), 0);
    chk({name, "_wvalid"}, 64'(axi.wvalid), 0);
    chk({name, "_tready"}, 64'(s_tready), 0);
    chk({name, "_bready"}, 64'(axi.bready), 1);
    chk({name, "_awaddr"}, 64'(axi.awaddr), 0);
  endtask

  initial begin
    int n;
    int n_done;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: aligned 32 words, always ready
    run_job(32'h1000_0000, 32, 3, 100, -1, 1'b0, "t1");
    n_done = done_cnt;
    repeat (6) @(posedge clk);
    chk("t1_done_once", 64'(done_cnt), 64'(n_done));

    // 2: unaligned start, 3/16/1 split
    run_job(32'h1000_0068, 20, 2, 100, -1, 1'b0, "t2");

    // 3: zero-length job
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    cfg_addr  = 32'h3000_0000;
    cfg_words = '0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t3_busy", 64'(busy), 1);
    chk("t3_done", 64'(done), 1);
    chk("t3_awvalid", 64'(axi.awvalid), 0);
    @(negedge clk);
    chk("t3_busy_end", 64'(busy), 0);
    chk("t3_done_end", 64'(done), 0);

    // 4: random gaps, slow BRESP, ignored start while busy
    max_outst = 0;
    run_job({$urandom} & 32'hFFFF_FFF8, 100, 50, 70, -1, 1'b1, "t4");
    chk("t4_outst_bound", 64'(max_outst <= MAX_OUTST), 1);

    // 5: SLVERR on middle burst, then a clean job clears err
    run_job(32'h2000_0000, 48, 4, 90, 1, 1'b0, "t5");
    run_job(32'h2000_1000, 8, 2, 100, -1, 1'b0, "t5b");

    // 6: reset mid-burst, then a clean job
    b_delay   = 2;
    rdy_pct   = 100;
    err_burst = -1;
    burst_idx = 0;
    w_hs_cnt  = 0;
    plan_job(32'h4000_0000, 16);
    pulse_start(32'h4000_0000, 16);
    n = 0;
    while (w_hs_cnt < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t6_reached_beat5", 64'(w_hs_cnt >= 5), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    s_tvalid = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    src_q.delete();
    b_due.delete();
    tb_outst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_job(32'h4000_0200, 24, 3, 80, -1, 1'b0, "t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
